// File: rtl/rob_commit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rob_commit_pkg
// Brief   : Shared widths and entry-state encoding for the reorder buffer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package rob_commit_pkg;

  // Datapath widths, given as MSB indices (field width = value + 1)
  localparam int PcLength     = 31;
  localparam int DataLength   = 31;
  localparam int OpcodeLength = 6;

  // Default geometry of the buffer
  localparam int RobDepthDefault     = 16;
  localparam int RobPtrLengthDefault = 3;

  // Lifecycle of one reorder-buffer slot
  typedef enum logic [1:0] {
    RobEmpty  = 2'd0,
    RobIssued = 2'd1,
    RobReady  = 2'd2
  } rob_state_e;

endpackage : rob_commit_pkg
`default_nettype wire

// File: rtl/rob_commit_tag_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rob_tag_match
// Brief   : Oldest-first priority finder over the per-slot CDB match vector.
//           Age is measured from head, so the search wraps around the ring.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module rob_tag_match #(
  parameter int RobDepth     = 16,
  parameter int RobPtrLength = 3
) (
  input  logic [RobDepth-1:0]   match,
  input  logic [RobPtrLength:0] head,
  output logic                  hit,
  output logic [RobPtrLength:0] index
);

  localparam int PtrW = RobPtrLength + 1;

  logic [RobPtrLength:0] slot;

  // Scan youngest to oldest so the oldest matching slot wins the last assignment
  always_comb begin
    hit   = 1'b0;
    index = head;
    slot  = head;
    for (int k = RobDepth - 1; k >= 0; k--) begin
      slot = head + PtrW'(k);
      if (match[slot]) begin
        hit   = 1'b1;
        index = slot;
      end
    end
  end

endmodule : rob_tag_match
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rob_commit
// Brief   : Reorder buffer. Accepts in-order issue, marks entries complete
//           from the CDB, retires one entry per cycle into the register file
//           and flushes everything when a mispredicted jump retires.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int RobDepth     = RobDepthDefault,
  parameter int RobPtrLength = RobPtrLengthDefault,
  parameter int RdLength     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    is_empty_from_rf,
  input  logic [PcLength:0]       pc_from_rf,
  input  logic [RdLength:0]       rd_from_rf,
  input  logic [OpcodeLength:0]   op_from_rf,
  input  logic                    is_finish_from_cdb,
  input  logic [PcLength:0]       pc_from_cdb,
  input  logic [DataLength:0]     data_from_cdb,
  input  logic                    is_jump_wrong_from_cdb,
  input  logic [PcLength:0]       target_from_cdb,
  output logic                    is_full_to_decoder,
  output logic                    is_finish_to_rf,
  output logic [RdLength:0]       rd_to_rf,
  output logic [DataLength:0]     data_to_rf,
  output logic [PcLength:0]       pc_to_rf,
  output logic                    is_exception_to_rf,
  output logic [PcLength:0]       target_pc_to_fetch
);

  // Count needs one more bit than the pointers to represent "full"
  localparam int CntW = RobPtrLength + 2;

  rob_state_e              state      [RobDepth];
  logic [PcLength:0]       pc_mem     [RobDepth];
  logic [RdLength:0]       rd_mem     [RobDepth];
  logic [DataLength:0]     data_mem   [RobDepth];
  logic                    jw_mem     [RobDepth];
  logic [PcLength:0]       tgt_mem    [RobDepth];
  // Opcode is kept for waveform debug only; no datapath logic reads it
  logic [OpcodeLength:0]   dbg_op_unused [RobDepth];

  logic [RobPtrLength:0]   head;
  logic [RobPtrLength:0]   tail;
  logic [CntW-1:0]         count;
  logic [CntW-1:0]         count_next;

  logic [RobDepth-1:0]     cdb_match;
  logic                    cdb_hit;
  logic [RobPtrLength:0]   cdb_idx;
  logic                    issue_ok;
  logic                    commit_now;
  logic                    flush_now;

  // Only entries already ISSUED before this edge can take a writeback
  always_comb begin
    cdb_match = '0;
    for (int i = 0; i < RobDepth; i++) begin
      cdb_match[i] = is_finish_from_cdb && (state[i] == RobIssued) &&
                     (pc_mem[i] == pc_from_cdb);
    end
  end

  rob_tag_match #(
    .RobDepth     (RobDepth),
    .RobPtrLength (RobPtrLength)
  ) u_tag_match (
    .match (cdb_match),
    .head  (head),
    .hit   (cdb_hit),
    .index (cdb_idx)
  );

  assign issue_ok   = !is_empty_from_rf && (count != CntW'(RobDepth));
  assign commit_now = (state[head] == RobReady);
  assign flush_now  = commit_now && jw_mem[head];

  // Occupancy bookkeeping; simultaneous issue and commit cancel out
  always_comb begin
    count_next = count;
    if (issue_ok && !commit_now)      count_next = count + 1'b1;
    else if (!issue_ok && commit_now) count_next = count - 1'b1;
  end

  // Slot lifecycle; a flushing commit empties every slot and drops same-cycle events
  always_ff @(posedge clk) begin
    if (rst || flush_now) begin
      for (int i = 0; i < RobDepth; i++) state[i] <= RobEmpty;
    end else begin
      if (commit_now) state[head]    <= RobEmpty;
      if (cdb_hit)    state[cdb_idx] <= RobReady;
      if (issue_ok)   state[tail]    <= RobIssued;
    end
  end

  // Payload storage; stale contents are harmless because state gates every read
  always_ff @(posedge clk) begin
    if (issue_ok) begin
      pc_mem[tail]        <= pc_from_rf;
      rd_mem[tail]        <= rd_from_rf;
      dbg_op_unused[tail] <= op_from_rf;
    end
    if (cdb_hit) begin
      data_mem[cdb_idx] <= data_from_cdb;
      jw_mem[cdb_idx]   <= is_jump_wrong_from_cdb;
      tgt_mem[cdb_idx]  <= target_from_cdb;
    end
  end

  // Pointers, count and the registered full flag
  always_ff @(posedge clk) begin
    if (rst || flush_now) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      is_full_to_decoder <= 1'b0;
    end else begin
      if (commit_now) head <= head + 1'b1;
      if (issue_ok)   tail <= tail + 1'b1;
      count              <= count_next;
      is_full_to_decoder <= (count_next == CntW'(RobDepth));
    end
  end

  // Commit and redirect outputs; data fields hold between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      is_finish_to_rf    <= 1'b0;
      rd_to_rf           <= '0;
      data_to_rf         <= '0;
      pc_to_rf           <= '0;
      is_exception_to_rf <= 1'b0;
      target_pc_to_fetch <= '0;
    end else begin
      is_finish_to_rf    <= commit_now;
      is_exception_to_rf <= flush_now;
      if (commit_now) begin
        rd_to_rf   <= rd_mem[head];
        data_to_rf <= data_mem[head];
        pc_to_rf   <= pc_mem[head];
      end
      if (flush_now) target_pc_to_fetch <= tgt_mem[head];
    end
  end

endmodule : rob_commit
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_rob_commit
// Brief   : Directed bench for rob_commit: a vector table for in-order commit
//           and mispredict flush, then hand sequences for full/wrap, duplicate
//           tags, mid-flight reset and unmatched/same-cycle writebacks.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_empty_from_rf;
  logic [31:0] pc_from_rf;
  logic [4:0]  rd_from_rf;
  logic [6:0]  op_from_rf;
  logic        is_finish_from_cdb;
  logic [31:0] pc_from_cdb;
  logic [31:0] data_from_cdb;
  logic        is_jump_wrong_from_cdb;
  logic [31:0] target_from_cdb;
  logic        is_full_to_decoder;
  logic        is_finish_to_rf;
  logic [4:0]  rd_to_rf;
  logic [31:0] data_to_rf;
  logic [31:0] pc_to_rf;
  logic        is_exception_to_rf;
  logic [31:0] target_pc_to_fetch;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk                    (clk),
    .rst                    (rst),
    .is_empty_from_rf       (is_empty_from_rf),
    .pc_from_rf             (pc_from_rf),
    .rd_from_rf             (rd_from_rf),
    .op_from_rf             (op_from_rf),
    .is_finish_from_cdb     (is_finish_from_cdb),
    .pc_from_cdb            (pc_from_cdb),
    .data_from_cdb          (data_from_cdb),
    .is_jump_wrong_from_cdb (is_jump_wrong_from_cdb),
    .target_from_cdb        (target_from_cdb),
    .is_full_to_decoder     (is_full_to_decoder),
    .is_finish_to_rf        (is_finish_to_rf),
    .rd_to_rf               (rd_to_rf),
    .data_to_rf             (data_to_rf),
    .pc_to_rf               (pc_to_rf),
    .is_exception_to_rf     (is_exception_to_rf),
    .target_pc_to_fetch     (target_pc_to_fetch)
  );

  // One table row = stimulus for one cycle plus every output expected after its edge
  typedef struct {
    logic        iss;
    logic [31:0] ipc;
    logic [4:0]  ird;
    logic        cdb;
    logic [31:0] cpc;
    logic [31:0] cdata;
    logic        cjw;
    logic [31:0] ctgt;
    logic        e_fin;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_pc;
    logic        e_exc;
    logic [31:0] e_tgt;
    logic        e_full;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iss, input logic [31:0] ipc, input logic [4:0] ird,
                       input logic cdb, input logic [31:0] cpc, input logic [31:0] cdata,
                       input logic cjw, input logic [31:0] ctgt);
    is_empty_from_rf       = !iss;
    pc_from_rf             = ipc;
    rd_from_rf             = ird;
    op_from_rf             = ipc[6:0];
    is_finish_from_cdb     = cdb;
    pc_from_cdb            = cpc;
    data_from_cdb          = cdata;
    is_jump_wrong_from_cdb = cjw;
    target_from_cdb        = ctgt;
  endtask

  // Advance one edge and sample outputs 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
  endtask

  task automatic issue(input logic [31:0] ipc, input logic [4:0] ird);
    drive(1'b1, ipc, ird, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
  endtask

  task automatic wb(input logic [31:0] cpc, input logic [31:0] cdata);
    drive(1'b0, 32'h0, 5'd0, 1'b1, cpc, cdata, 1'b0, 32'h0);
    step();
  endtask

  task automatic chk_commit(input string name, input logic [4:0] rd, input logic [31:0] data,
                            input logic [31:0] pc);
    chk({name, ".fin"},  {31'd0, is_finish_to_rf}, 32'd1);
    chk({name, ".rd"},   {27'd0, rd_to_rf}, {27'd0, rd});
    chk({name, ".data"}, data_to_rf, data);
    chk({name, ".pc"},   pc_to_rf, pc);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".fin"},  {31'd0, is_finish_to_rf}, 32'd0);
    chk({name, ".rd"},   {27'd0, rd_to_rf}, 32'd0);
    chk({name, ".data"}, data_to_rf, 32'd0);
    chk({name, ".pc"},   pc_to_rf, 32'd0);
    chk({name, ".exc"},  {31'd0, is_exception_to_rf}, 32'd0);
    chk({name, ".tgt"},  target_pc_to_fetch, 32'd0);
    chk({name, ".full"}, {31'd0, is_full_to_decoder}, 32'd0);
  endtask

  initial begin
    // In-order commit of out-of-order completions, then a mispredict flush
    //          iss  ipc       ird   cdb  cpc       cdata     jw   ctgt      fin  rd    data      pc        exc  tgt       full
    tbl[0]  = '{1'b1, 32'h100, 5'd1, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0};
    tbl[1]  = '{1'b1, 32'h104, 5'd2, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0};
    tbl[2]  = '{1'b1, 32'h108, 5'd3, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0};
    tbl[3]  = '{1'b0, 32'h0,   5'd0, 1'b1, 32'h108, 32'hC,   1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0};
    tbl[4]  = '{1'b0, 32'h0,   5'd0, 1'b1, 32'h100, 32'hA,   1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0};
    tbl[5]  = '{1'b0, 32'h0,   5'd0, 1'b1, 32'h104, 32'hB,   1'b0, 32'h0,   1'b1, 5'd1, 32'hA,   32'h100, 1'b0, 32'h0,   1'b0};
    tbl[6]  = '{1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b1, 5'd2, 32'hB,   32'h104, 1'b0, 32'h0,   1'b0};
    tbl[7]  = '{1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b1, 5'd3, 32'hC,   32'h108, 1'b0, 32'h0,   1'b0};
    tbl[8]  = '{1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0, 5'd3, 32'hC,   32'h108, 1'b0, 32'h0,   1'b0};
    tbl[9]  = '{1'b1, 32'h300, 5'd5, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0, 5'd3, 32'hC,   32'h108, 1'b0, 32'h0,   1'b0};
    tbl[10] = '{1'b1, 32'h304, 5'd6, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0, 5'd3, 32'hC,   32'h108, 1'b0, 32'h0,   1'b0};
    tbl[11] = '{1'b0, 32'h0,   5'd0, 1'b1, 32'h300, 32'h55,  1'b1, 32'h400, 1'b0, 5'd3, 32'hC,   32'h108, 1'b0, 32'h0,   1'b0};
    tbl[12] = '{1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b1, 5'd5, 32'h55,  32'h300, 1'b1, 32'h400, 1'b0};
    tbl[13] = '{1'b0, 32'h0,   5'd0, 1'b1, 32'h304, 32'h66,  1'b0, 32'h0,   1'b0, 5'd5, 32'h55,  32'h300, 1'b0, 32'h400, 1'b0};
    tbl[14] = '{1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0, 5'd5, 32'h55,  32'h300, 1'b0, 32'h400, 1'b0};

    rst = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].iss, tbl[r].ipc, tbl[r].ird, tbl[r].cdb, tbl[r].cpc,
            tbl[r].cdata, tbl[r].cjw, tbl[r].ctgt);
      step();
      chk($sformatf("row%0d.fin", r),  {31'd0, is_finish_to_rf},    {31'd0, tbl[r].e_fin});
      chk($sformatf("row%0d.rd", r),   {27'd0, rd_to_rf},           {27'd0, tbl[r].e_rd});
      chk($sformatf("row%0d.data", r), data_to_rf,                  tbl[r].e_data);
      chk($sformatf("row%0d.pc", r),   pc_to_rf,                    tbl[r].e_pc);
      chk($sformatf("row%0d.exc", r),  {31'd0, is_exception_to_rf}, {31'd0, tbl[r].e_exc});
      chk($sformatf("row%0d.tgt", r),  target_pc_to_fetch,          tbl[r].e_tgt);
      chk($sformatf("row%0d.full", r), {31'd0, is_full_to_decoder}, {31'd0, tbl[r].e_full});
    end

    // Fill all 16 slots starting from slot 0 (the flush reset the pointers)
    for (int i = 0; i < 16; i++) begin
      issue(32'h1000 + 32'(4 * i), 5'(i));
      chk($sformatf("fill%0d.full", i), {31'd0, is_full_to_decoder}, (i == 15) ? 32'd1 : 32'd0);
    end
    issue(32'h200, 5'd9);
    chk("drop17.full", {31'd0, is_full_to_decoder}, 32'd1);
    chk("drop17.fin",  {31'd0, is_finish_to_rf}, 32'd0);
    wb(32'h1000, 32'h77);
    chk("full_wb.full", {31'd0, is_full_to_decoder}, 32'd1);
    idle();
    chk_commit("full_c0", 5'd0, 32'h77, 32'h1000);
    chk("full_c0.full", {31'd0, is_full_to_decoder}, 32'd0);
    issue(32'h200, 5'd9);
    chk("wrap_issue.full", {31'd0, is_full_to_decoder}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      wb(32'h1000 + 32'(4 * i), 32'h100 + 32'(i));
      chk($sformatf("drain%0d.nofin", i), {31'd0, is_finish_to_rf}, 32'd0);
      idle();
      chk_commit($sformatf("drain%0d", i), 5'(i), 32'h100 + 32'(i), 32'h1000 + 32'(4 * i));
    end
    wb(32'h200, 32'h99);
    idle();
    chk_commit("wrap_c", 5'd9, 32'h99, 32'h200);
    chk("wrap_c.full", {31'd0, is_full_to_decoder}, 32'd0);

    // Duplicate tag: only the older entry takes the writeback
    issue(32'h500, 5'd1);
    issue(32'h500, 5'd2);
    wb(32'h500, 32'd7);
    chk("dup_wb.fin", {31'd0, is_finish_to_rf}, 32'd0);
    idle();
    chk_commit("dup_old", 5'd1, 32'd7, 32'h500);
    idle();
    chk("dup_young_wait.fin", {31'd0, is_finish_to_rf}, 32'd0);
    wb(32'h500, 32'd8);
    idle();
    chk_commit("dup_young", 5'd2, 32'd8, 32'h500);

    // Reset with five entries in flight and the head READY at the reset edge
    for (int i = 0; i < 5; i++) issue(32'h700 + 32'(4 * i), 5'(i + 1));
    wb(32'h704, 32'h1);
    wb(32'h708, 32'h2);
    wb(32'h700, 32'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("midreset");
    idle();
    chk("post_reset.fin", {31'd0, is_finish_to_rf}, 32'd0);
    issue(32'h720, 5'd4);
    wb(32'h720, 32'h21);
    idle();
    chk_commit("post_reset_c", 5'd4, 32'h21, 32'h720);

    // Same-cycle issue+writeback must not complete; unmatched tag is ignored
    drive(1'b1, 32'h604, 5'd7, 1'b1, 32'h604, 32'h44, 1'b0, 32'h0);
    step();
    wb(32'h600, 32'h11);
    chk("nomatch_a.fin", {31'd0, is_finish_to_rf}, 32'd0);
    idle();
    chk("nomatch_b.fin", {31'd0, is_finish_to_rf}, 32'd0);
    idle();
    chk("nomatch_c.fin", {31'd0, is_finish_to_rf}, 32'd0);
    chk("nomatch_c.pc",  pc_to_rf, 32'h720);
    wb(32'h604, 32'h45);
    idle();
    chk_commit("late_wb", 5'd7, 32'h45, 32'h604);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rob_commit
`default_nettype wire
